// File: rtl/sort_pkg.sv
// Shared definitions for the sort stage and its read-side drain.
// Holds the drain state encoding, default bank geometry and index-width helper.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } drain_state_e;

  localparam int SORT_DEPTH  = 8;
  localparam int SORT_DATA_W = 8;

  // A two-entry bank still needs one index bit.
  function automatic int idx_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sort_idx_counter.sv
// Loadable up/down index counter with terminal flag; read-side mirror of the writer's counter.
// Latency: idx updates one cycle after load/en; term is combinational from the held index.
// Backpressure: none; the step is simply withheld while en is low or term is set.
module sort_idx_counter
  import sort_pkg::*;
#(
  parameter int              IDX_W   = 3,
  parameter int              DEPTH   = 8,
  parameter logic [IDX_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IDX_W-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [IDX_W-1:0] idx,
  output logic             term
);

  localparam logic [IDX_W-1:0] LAST_UP = IDX_W'(DEPTH - 1);

  logic [IDX_W-1:0] idx_d, idx_q;

  // Stepping stops at the terminal value, so a power-of-two DEPTH never wraps.
  always_comb begin
    term  = dir ? (idx_q == '0) : (idx_q == LAST_UP);
    idx_d = idx_q;
    if (load) begin
      idx_d = load_val;
    end else if (en && !term) begin
      idx_d = dir ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= RST_VAL;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/sort_drain.sv
// Snapshots a sorted bank on start and streams it out one element per valid/ready beat.
// Latency: LOAD cycle after the start edge, then one beat per accepted handshake; done pulses after the last.
// Backpressure: beat held stable while out_ready=0; optional abort input under SORT_DRAIN_ABORT_EN.
module sort_drain
  import sort_pkg::*;
#(
  parameter int  DEPTH   = SORT_DEPTH,
  parameter int  DATA_W  = SORT_DATA_W,
  parameter int  DESCEND = 0,
  localparam int IDX_W   = idx_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
`ifdef SORT_DRAIN_ABORT_EN
  input  logic                    abort,
`endif
  input  logic [DEPTH*DATA_W-1:0] bank_in,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    done
);

  localparam logic [IDX_W-1:0] START_IDX = (DESCEND != 0) ? IDX_W'(DEPTH - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = (DESCEND != 0) ? '0 : IDX_W'(DEPTH - 1);

  drain_state_e            state_d, state_q;
  logic [DEPTH*DATA_W-1:0] snap_d, snap_q;
  logic                    valid_d, valid_q;
  logic [DATA_W-1:0]       data_d, data_q;
  logic                    last_d, last_q;
  logic                    done_d, done_q;
  logic                    busy_d, busy_q;
  logic                    cnt_load, cnt_en, cnt_term, hs;
  logic [IDX_W-1:0]        cnt_idx, idx_step;

  function automatic logic [DATA_W-1:0] elem(input logic [DEPTH*DATA_W-1:0] b,
                                             input logic [IDX_W-1:0] i);
    return b[int'(i)*DATA_W +: DATA_W];
  endfunction

  sort_idx_counter #(
    .IDX_W  (IDX_W),
    .DEPTH  (DEPTH),
    .RST_VAL(START_IDX)
  ) u_idx (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(START_IDX),
    .en      (cnt_en),
    .dir     (DESCEND != 0),
    .idx     (cnt_idx),
    .term    (cnt_term)
  );

  assign hs       = valid_q && out_ready;
  assign idx_step = (DESCEND != 0) ? (cnt_idx - IDX_W'(1)) : (cnt_idx + IDX_W'(1));

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    valid_d  = valid_q;
    data_d   = data_q;
    last_d   = last_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d   = bank_in;
          cnt_load = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        state_d = STREAM;
        valid_d = 1'b1;
        data_d  = elem(snap_q, cnt_idx);
        last_d  = cnt_term;
      end
      STREAM: begin
        // valid low here means this is the done cycle; start is still ignored.
        if (!valid_q) begin
          state_d = IDLE;
        end else if (hs) begin
          if (cnt_term) begin
            valid_d  = 1'b0;
            last_d   = 1'b0;
            done_d   = 1'b1;
            cnt_load = 1'b1;
          end else begin
            cnt_en = 1'b1;
            data_d = elem(snap_q, idx_step);
            last_d = (idx_step == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef SORT_DRAIN_ABORT_EN
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      valid_d  = 1'b0;
      last_d   = 1'b0;
      done_d   = 1'b0;
      cnt_load = 1'b1;
      cnt_en   = 1'b0;
    end
`endif
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_idx   = cnt_idx;
  assign out_last  = last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sort_drain.sv
// Bench for sort_drain: ascending and descending instances share stimulus and one reference model.
module tb_sort_drain;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst = 1'b1, start = 1'b0, out_ready = 1'b0, abort_v = 1'b0;
  logic [DEPTH*DATA_W-1:0] bank_in = '0;

  logic              busy_a, valid_a, last_a, done_a;
  logic              busy_d, valid_d, last_d, done_d;
  logic [DATA_W-1:0] data_a, data_d;
  logic [IDX_W-1:0]  idx_a, idx_d;

  sort_drain #(.DEPTH(DEPTH), .DATA_W(DATA_W), .DESCEND(0)) dut_a (
    .clk(clk), .rst(rst), .start(start),
`ifdef SORT_DRAIN_ABORT_EN
    .abort(abort_v),
`endif
    .bank_in(bank_in), .busy(busy_a), .out_valid(valid_a), .out_ready(out_ready),
    .out_data(data_a), .out_idx(idx_a), .out_last(last_a), .done(done_a)
  );

  sort_drain #(.DEPTH(DEPTH), .DATA_W(DATA_W), .DESCEND(1)) dut_d (
    .clk(clk), .rst(rst), .start(start),
`ifdef SORT_DRAIN_ABORT_EN
    .abort(abort_v),
`endif
    .bank_in(bank_in), .busy(busy_d), .out_valid(valid_d), .out_ready(out_ready),
    .out_data(data_d), .out_idx(idx_d), .out_last(last_d), .done(done_d)
  );

  int checks = 0, errors = 0;
  int lit[8] = '{7, 3, 9, 1, 0, 5, 2, 8};
  logic [15:0] acc_a[$], acc_d[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a drain is a list of DEPTH beats taken from a snapshot; m_pos counts accepted beats.
  bit                m_live = 0, m_idle = 1, m_load = 0, m_valid = 0, m_post = 0, m_done = 0;
  int                m_pos = 0;
  logic [DATA_W-1:0] m_snap[DEPTH];

  always @(posedge clk) begin
    m_done = 0;
    if (rst) begin
      m_live = 1; m_idle = 1; m_load = 0; m_valid = 0; m_post = 0;
    end else if (abort_v && !m_idle) begin
      m_idle = 1; m_load = 0; m_valid = 0; m_post = 0;
    end else if (m_idle) begin
      if (start) begin
        for (int i = 0; i < DEPTH; i++) m_snap[i] = bank_in[i*DATA_W +: DATA_W];
        m_pos = 0; m_idle = 0; m_load = 1;
      end
    end else if (m_load) begin
      m_load = 0; m_valid = 1;
    end else if (m_valid) begin
      if (out_ready) begin
        if (m_pos == DEPTH - 1) begin
          m_valid = 0; m_done = 1; m_post = 1;
        end else begin
          m_pos++;
        end
      end
    end else if (m_post) begin
      m_post = 0; m_idle = 1;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("valid_a", valid_a, m_valid);
      chk("valid_d", valid_d, m_valid);
      chk("done_a", done_a, m_done);
      chk("done_d", done_d, m_done);
      chk("busy_a", busy_a, !m_idle);
      chk("busy_d", busy_d, !m_idle);
      if (m_valid) begin
        chk("idx_a", idx_a, m_pos);
        chk("idx_d", idx_d, DEPTH - 1 - m_pos);
        chk("data_a", data_a, m_snap[m_pos]);
        chk("data_d", data_d, m_snap[DEPTH-1-m_pos]);
        chk("last_a", last_a, m_pos == DEPTH - 1);
        chk("last_d", last_d, m_pos == DEPTH - 1);
      end
    end
  end

  // Beats the consumer will take at the coming edge.
  always @(negedge clk) begin
    if (!rst && !abort_v && out_ready) begin
      if (valid_a) acc_a.push_back({5'd0, idx_a, data_a});
      if (valid_d) acc_d.push_back({5'd0, idx_d, data_d});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bank_lit();
    for (int i = 0; i < DEPTH; i++) bank_in[i*DATA_W +: DATA_W] = 8'(lit[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done_a && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) chk("done_timeout", done_a, 1);
  endtask

  task automatic check_lit(input string nm, input bit desc);
    logic [15:0] q[$];
    int          ix;
    if (desc) q = acc_d; else q = acc_a;
    chk({nm, "_count"}, q.size(), 8);
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      ix = desc ? 7 - i : i;
      chk({nm, "_idx"}, q[i][15:8], ix);
      chk({nm, "_data"}, q[i][7:0], lit[ix]);
    end
  endtask

  initial begin
    int n;
    int drains = 0;

    repeat (2) step();
    chk("rst_valid", valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_last", last_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_idx_a", idx_a, 0);
    chk("rst_idx_d", idx_d, 7);
    rst = 1'b0;
    set_bank_lit();
    out_ready = 1'b1;

    // Basic drains with ready held high.
    acc_a.delete(); acc_d.delete();
    pulse_start();
    chk("load_valid", valid_a, 0);
    wait_done(n);
    chk("done_latency", n, 9);
    step();
    check_lit("asc", 0);
    check_lit("desc", 1);

    // Backpressure pattern 1,0,0,1.
    acc_a.delete(); acc_d.delete();
    pulse_start();
    n = 0;
    while (!done_a && n < 200) begin
      out_ready = (n % 4 == 0) || (n % 4 == 3);
      step();
      n++;
    end
    if (n >= 200) chk("bp_timeout", done_a, 1);
    out_ready = 1'b1;
    step();
    check_lit("bp_asc", 0);
    check_lit("bp_desc", 1);

    // Snapshot isolation and start while busy.
    acc_a.delete(); acc_d.delete();
    pulse_start();
    repeat (4) step();
    bank_in = '1;
    pulse_start();
    wait_done(n);
    step();
    check_lit("iso_asc", 0);
    chk("iso_idle", busy_a, 0);
    set_bank_lit();

    // Reset after beat 3 has been accepted.
    acc_a.delete(); acc_d.delete();
    pulse_start();
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", valid_a, 0);
    chk("mid_rst_idx_a", idx_a, 0);
    chk("mid_rst_idx_d", idx_d, 7);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_accepted", acc_a.size(), 4);
    repeat (3) step();
    acc_a.delete(); acc_d.delete();
    pulse_start();
    wait_done(n);
    step();
    check_lit("fresh_asc", 0);

`ifdef SORT_DRAIN_ABORT_EN
    acc_a.delete(); acc_d.delete();
    pulse_start();
    n = 0;
    while (!(valid_a && idx_a == 3'd2) && n < 20) begin
      step();
      n++;
    end
    abort_v = 1'b1;
    step();
    abort_v = 1'b0;
    chk("abort_valid", valid_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_accepted", acc_a.size(), 2);
    repeat (3) step();
`endif

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) bank_in = {$urandom, $urandom};
      rst       = ($urandom_range(0, 199) == 0);
`ifdef SORT_DRAIN_ABORT_EN
      abort_v   = ($urandom_range(0, 99) == 0);
`endif
      step();
      if (done_a) drains++;
    end
    start = 1'b0; rst = 1'b0; abort_v = 1'b0;
    step();
    chk("random_drains_seen", drains > 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
